ula_arbiter: RTL

- Shares one ula instance between two requesters, e.g. the execute stage (port 0) and a branch/address helper (port 1).
- Valid/ready request handshake per port; round-robin arbitration; registered result and Zero_Flag returned on a per-port response handshake.
- One transaction in flight at a time.
- Per-port saturating grant counters for performance visibility.

---
 rtl/ula_arbiter_pkg.sv | 21 ++
 rtl/ula_arbiter_ula.sv | 45 ++++
 rtl/ula_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ula_arbiter_pkg.sv
// Shared opcode constants for the ula and the arbiter that fronts it.
// Codes 4'd15 is left undefined; the ula returns 0 for it.
package ula_arbiter_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_SLLV = 4'd11;
   localparam logic [3:0] OP_SRLV = 4'd12;
   localparam logic [3:0] OP_SRAV = 4'd13;
   localparam logic [3:0] OP_JR   = 4'd14;

endpackage

// File: rtl/ula_arbiter_ula.sv
// Combinational ula shared by the arbiter ports.
// Ports:
//   in1       operand 1; bits [4:0] are the shift amount for shift ops
//   in2       operand 2; the value being shifted for shift ops
//   op        opcode (see ula_arbiter_pkg)
//   result    32-bit result, 0 for undefined opcodes
//   zero_flag high when result is 0
module ula_arbiter_ula
   import ula_arbiter_pkg::*;
(
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [3:0]  op,
   output logic [31:0] result,
   output logic        zero_flag
);

   logic [4:0] shamt;
   assign shamt = in1[4:0];

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = in1 + in2;
         OP_SUB:  result = in1 - in2;
         OP_AND:  result = in1 & in2;
         OP_OR:   result = in1 | in2;
         OP_XOR:  result = in1 ^ in2;
         OP_NOR:  result = ~(in1 | in2);
         OP_SLT:  result = {31'b0, $signed(in1) < $signed(in2)};
         OP_SLTU: result = {31'b0, in1 < in2};
         OP_SLL,
         OP_SLLV: result = in2 << shamt;
         OP_SRL,
         OP_SRLV: result = in2 >> shamt;
         OP_SRA,
         OP_SRAV: result = 32'($signed(in2) >>> shamt);
         OP_JR:   result = in1;
         default: result = '0;
      endcase
   end

   assign zero_flag = (result == 32'd0);

endmodule

// File: rtl/ula_arbiter.sv
// Two-port round-robin front end for a single ula. One transaction in
// flight; the registered result is returned on the owner's response port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready            request handshake, port N
//   reqN_in1/in2/op             operands and opcode, port N
//   rspN_valid/ready            response handshake, port N
//   rspN_result/zero            registered ula result and zero flag
//   busy                        a result is being held (RESP)
//   grant_cnt0/1                saturating grant counters
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no result held; any single grant is accepted
// RESP  | result held for owner; new grant only as it retires
module ula_arbiter
   import ula_arbiter_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter bit INIT_PRIO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_in1,
   input  logic [31:0]      req0_in2,
   input  logic [3:0]       req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_result,
   output logic             rsp0_zero,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_in1,
   input  logic [31:0]      req1_in2,
   input  logic [3:0]       req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_result,
   output logic             rsp1_zero,
   output logic             busy,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RESP = 1'b1;

   logic [0:0]  state;
   logic        owner;
   logic        prio;
   logic        can_accept;
   logic        grant0, grant1;
   logic        acc0, acc1;
   logic [31:0] alu_in1, alu_in2, alu_result;
   logic [3:0]  alu_op;
   logic        alu_zero;

   assign can_accept = (state == IDLE) ||
                       (owner ? rsp1_ready : rsp0_ready);

   assign grant0 = req0_valid && (!req1_valid || !prio);
   assign grant1 = req1_valid && (!req0_valid ||  prio);

   // rst_n gating keeps ready low while reset is held, even though the
   // registered state already reads IDLE.
   assign req0_ready = rst_n && can_accept && grant0;
   assign req1_ready = rst_n && can_accept && grant1;

   assign acc0 = req0_valid && req0_ready;
   assign acc1 = req1_valid && req1_ready;

   assign alu_in1 = grant1 ? req1_in1 : req0_in1;
   assign alu_in2 = grant1 ? req1_in2 : req0_in2;
   assign alu_op  = grant1 ? req1_op  : req0_op;

   ula_arbiter_ula u_ula (
      .in1       (alu_in1),
      .in2       (alu_in2),
      .op        (alu_op),
      .result    (alu_result),
      .zero_flag (alu_zero)
   );

   assign busy = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         prio        <= INIT_PRIO;
         rsp0_valid  <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp1_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp1_zero   <= 1'b0;
         grant_cnt0  <= '0;
         grant_cnt1  <= '0;
      end else if (acc0 || acc1) begin
         state      <= RESP;
         owner      <= acc1;
         prio       <= !acc1;
         rsp0_valid <= acc0;
         rsp1_valid <= acc1;
         if (acc0) begin
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
            if (grant_cnt0 != {CNT_W{1'b1}})
               grant_cnt0 <= grant_cnt0 + 1'b1;
         end else begin
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
            if (grant_cnt1 != {CNT_W{1'b1}})
               grant_cnt1 <= grant_cnt1 + 1'b1;
         end
      end else if ((state == RESP) && can_accept) begin
         state      <= IDLE;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end
   end

endmodule
